// File: rtl/exc_ctrl_pkg.sv
// Pipeline definitions shared by the exception controller and its users.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package exc_ctrl_pkg;

    // Bit positions inside the decode vector
    localparam int VEC_VLD_BIT = 4;

    // Cause codes
    localparam logic [3:0] CAUSE_TRAP0 = 4'h0;
    localparam logic [3:0] CAUSE_TRAP1 = 4'h1;
    localparam logic [3:0] CAUSE_TRAP2 = 4'h2;
    localparam logic [3:0] CAUSE_TRAP3 = 4'h3;
    localparam logic [3:0] CAUSE_TRAP4 = 4'h4;
    localparam logic [3:0] CAUSE_TRAP5 = 4'h5;
    localparam logic [3:0] CAUSE_TRAP6 = 4'h6;
    localparam logic [3:0] CAUSE_TRAP7 = 4'h7;
    localparam logic [3:0] CAUSE_UNDEF = 4'h8;
    localparam logic [3:0] CAUSE_INT   = 4'hF;

    // Mode encodings for s_u
    localparam logic S_USER  = 1'b1;
    localparam logic S_SUPER = 1'b0;

    // Default handler layout and flush length
    localparam logic [31:0] DEF_VEC_BASE     = 32'h0000_0080;
    localparam int          DEF_VEC_SH       = 3;
    localparam int          DEF_FLUSH_CYCLES = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Handler entry address; the add wraps at 32 bits.
    function automatic logic [31:0] handler_addr(input logic [31:0] base,
                                                 input logic [3:0]  c,
                                                 input int unsigned sh);
        return base + ({28'b0, c} << sh);
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Decode-to-exception-controller bus plus the controller's status/redirect outputs.
// Latency: n/a (wires only).
// Backpressure: none; events are single-cycle and ignored while the controller is busy.
//
// master: decode side, drives vector_in/rfe/ext_int/epc_in, observes the rest.
// slave : exc_ctrl, consumes the event inputs, drives mode/flush/redirect/status.
interface exc_ctrl_if;
    logic [4:0]  vector_in;  // [4] exception valid, [3:0] cause
    logic        rfe;        // return-from-exception decoded
    logic        ext_int;    // level-sensitive external interrupt
    logic [31:0] epc_in;     // PC of the instruction carrying the event
    logic        s_u;        // 1 = user, 0 = supervisor
    logic        flush;      // squash IF/ID/EX
    logic        redirect;   // one-cycle fetch redirect pulse
    logic [31:0] target;     // redirect address
    logic [31:0] epc;        // saved exception PC
    logic [3:0]  cause;      // saved cause code
    logic        busy;       // controller not idle

    modport master (
        output vector_in, rfe, ext_int, epc_in,
        input  s_u, flush, redirect, target, epc, cause, busy
    );

    modport slave (
        input  vector_in, rfe, ext_int, epc_in,
        output s_u, flush, redirect, target, epc, cause, busy
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt responder: saves EPC/cause/mode, flushes, redirects fetch; rfe restores.
// Latency: flush rises 1 cycle after acceptance, lasts FLUSH_CYCLES; redirect on the last flush cycle.
// Backpressure: none; all events are dropped while busy (the instructions are being squashed).
//
// Ports: clk, reset (async, active-high); bus (exc_ctrl_if.slave) carries vector_in, rfe,
// ext_int, epc_in in and s_u, flush, redirect, target, epc, cause, busy out.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_BASE     = DEF_VEC_BASE,
    parameter int          VEC_SH       = DEF_VEC_SH,
    parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter logic [3:0]  INT_CAUSE    = CAUSE_INT
) (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.slave  bus
);

    localparam int             CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s_u_q, s_u_d;
    logic              saved_su_q, saved_su_d;
    logic [31:0]       epc_q, epc_d;
    logic [3:0]        cause_q, cause_d;
    logic [31:0]       target_q, target_d;
    logic              flush_q, flush_d;
    logic              redirect_q, redirect_d;

    logic              take_exc;
    logic              take_int;
    logic              take_rfe;
    logic [3:0]        evt_cause;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_u_d      = s_u_q;
        saved_su_d = saved_su_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        target_d   = target_q;
        flush_d    = 1'b0;
        redirect_d = 1'b0;

        // Priority: exception > interrupt (user mode only) > rfe
        take_exc  = bus.vector_in[VEC_VLD_BIT];
        take_int  = !take_exc && bus.ext_int && (s_u_q == S_USER);
        take_rfe  = !take_exc && !take_int && bus.rfe;
        evt_cause = take_exc ? bus.vector_in[3:0] : INT_CAUSE;

        case (state_q)
            ST_IDLE: begin
                if (take_exc || take_int) begin
                    epc_d      = bus.epc_in;
                    cause_d    = evt_cause;
                    saved_su_d = s_u_q;
                    s_u_d      = S_SUPER;
                    target_d   = handler_addr(VEC_BASE, evt_cause, VEC_SH);
                end else if (take_rfe) begin
                    s_u_d    = saved_su_q;
                    target_d = epc_q;
                end
                if (take_exc || take_int || take_rfe) begin
                    state_d    = ST_FLUSH;
                    cnt_d      = CNT_LOAD;
                    flush_d    = 1'b1;
                    // A one-cycle flush must redirect in its only cycle.
                    redirect_d = (CNT_LOAD == '0);
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    flush_d    = 1'b1;
                    redirect_d = (cnt_d == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s_u_q      <= S_SUPER;
            saved_su_q <= S_SUPER;
            epc_q      <= '0;
            cause_q    <= '0;
            target_q   <= '0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_u_q      <= s_u_d;
            saved_su_q <= saved_su_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            target_q   <= target_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.s_u      = s_u_q;
    assign bus.flush    = flush_q;
    assign bus.redirect = redirect_q;
    assign bus.target   = target_q;
    assign bus.epc      = epc_q;
    assign bus.cause    = cause_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus a randomized run vs a model.
// Latency: n/a.
// Backpressure: n/a.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    localparam int          FC = 2;
    localparam logic [31:0] VB = 32'h0000_0080;
    localparam int          SH = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exc_ctrl_if bus();

    exc_ctrl #(.VEC_BASE(VB), .VEC_SH(SH), .FLUSH_CYCLES(FC), .INT_CAUSE(4'hF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model: mode, saved mode, saved PC/cause, last target, and the
    // number of flush cycles still ahead (0 = idle).
    logic        m_su, m_saved;
    logic [31:0] m_epc, m_target;
    logic [3:0]  m_cause;
    int          m_left;

    function automatic void model_reset();
        m_su = 1'b0; m_saved = 1'b0; m_epc = '0; m_target = '0; m_cause = '0; m_left = 0;
    endfunction

    function automatic void model_step(input logic [4:0] v, input logic r, input logic e,
                                       input logic [31:0] pc);
        if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (v[4] || (e && m_su)) begin
            m_epc    = pc;
            m_cause  = v[4] ? v[3:0] : 4'hF;
            m_saved  = m_su;
            m_su     = 1'b0;
            m_target = VB + 32'(m_cause) * (32'd1 << SH);
            m_left   = FC;
        end else if (r) begin
            m_su     = m_saved;
            m_target = m_epc;
            m_left   = FC;
        end
    endfunction

    task automatic drive(input logic [4:0] v, input logic r, input logic e, input logic [31:0] pc);
        bus.vector_in = v; bus.rfe = r; bus.ext_int = e; bus.epc_in = pc;
    endtask

    // Advance one clock: the model consumes the inputs seen at the edge; returns at negedge.
    task automatic tick();
        @(posedge clk);
        model_step(bus.vector_in, bus.rfe, bus.ext_int, bus.epc_in);
        @(negedge clk);
    endtask

    // Reset offers no architectural route into user mode, so the bench puts the idle
    // controller there directly.
    task automatic set_user();
        force dut.s_u_q = 1'b1;
        #1;
        release dut.s_u_q;
        m_su = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(5'h00, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        if (bus.s_u !== 1'b0) begin n_bad++; $display("FAIL reset_s_u got %0b want 0", bus.s_u); end
        n_cmp++;
        if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %0b want 0", bus.flush); end
        n_cmp++;
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        if (bus.redirect !== 1'b0) begin n_bad++; $display("FAIL idle_redirect got %0b want 0", bus.redirect); end
        n_cmp++;
        if (bus.epc !== 32'h0) begin n_bad++; $display("FAIL idle_epc got %h want 0", bus.epc); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %0b want 0", bus.busy); end
        n_cmp++;
        if (bus.target !== 32'h0) begin n_bad++; $display("FAIL idle_target got %h want 0", bus.target); end
        n_cmp++;
    endtask

    task automatic test_exception();
        set_user();
        drive(5'h13, 1'b0, 1'b0, 32'h400);
        tick();
        drive(5'h00, 1'b0, 1'b0, 32'h404);
        if ({bus.flush, bus.redirect, bus.busy} !== 3'b101)
            begin n_bad++; $display("FAIL exc_f1 got f/r/b=%b want 101", {bus.flush, bus.redirect, bus.busy}); end
        n_cmp++;
        tick();
        if ({bus.flush, bus.redirect} !== 2'b11)
            begin n_bad++; $display("FAIL exc_f2 got f/r=%b want 11", {bus.flush, bus.redirect}); end
        n_cmp++;
        if (bus.target !== 32'h98) begin n_bad++; $display("FAIL exc_target got %h want 98", bus.target); end
        n_cmp++;
        if ({bus.epc, bus.cause, bus.s_u} !== {32'h400, 4'h3, 1'b0})
            begin n_bad++; $display("FAIL exc_state got epc=%h cause=%h s_u=%b want 400/3/0", bus.epc, bus.cause, bus.s_u); end
        n_cmp++;
        tick();
        if ({bus.flush, bus.redirect, bus.busy} !== 3'b000)
            begin n_bad++; $display("FAIL exc_done got f/r/b=%b want 000", {bus.flush, bus.redirect, bus.busy}); end
        n_cmp++;
    endtask

    task automatic test_rfe();
        drive(5'h00, 1'b1, 1'b0, 32'h1234);
        tick();
        drive(5'h00, 1'b0, 1'b0, 32'h1238);
        if ({bus.flush, bus.redirect} !== 2'b10)
            begin n_bad++; $display("FAIL rfe_f1 got f/r=%b want 10", {bus.flush, bus.redirect}); end
        n_cmp++;
        tick();
        if ({bus.redirect, bus.target} !== {1'b1, 32'h400})
            begin n_bad++; $display("FAIL rfe_redirect got r=%b tgt=%h want 1/400", bus.redirect, bus.target); end
        n_cmp++;
        if ({bus.s_u, bus.cause, bus.epc} !== {1'b1, 4'h3, 32'h400})
            begin n_bad++; $display("FAIL rfe_state got s_u=%b cause=%h epc=%h want 1/3/400", bus.s_u, bus.cause, bus.epc); end
        n_cmp++;
        tick();
    endtask

    task automatic test_ext_int();
        // User mode: undefined op in the same cycle as ext_int wins.
        drive(5'h18, 1'b0, 1'b1, 32'h500);
        tick();
        drive(5'h00, 1'b0, 1'b1, 32'h504);
        tick();
        if ({bus.redirect, bus.target, bus.cause} !== {1'b1, 32'hC0, 4'h8})
            begin n_bad++; $display("FAIL undef_entry got r=%b tgt=%h cause=%h want 1/c0/8", bus.redirect, bus.target, bus.cause); end
        n_cmp++;
        // Held ext_int is now ignored: supervisor mode.
        tick();
        tick();
        tick();
        if ({bus.flush, bus.busy, bus.cause} !== {1'b0, 1'b0, 4'h8})
            begin n_bad++; $display("FAIL int_super got f=%b b=%b cause=%h want 0/0/8", bus.flush, bus.busy, bus.cause); end
        n_cmp++;
        // rfe back to user with ext_int still held; it re-enters once idle again.
        drive(5'h00, 1'b1, 1'b1, 32'h508);
        tick();
        drive(5'h00, 1'b0, 1'b1, 32'h50C);
        tick();
        if ({bus.redirect, bus.target, bus.s_u} !== {1'b1, 32'h500, 1'b1})
            begin n_bad++; $display("FAIL rfe_to_user got r=%b tgt=%h s_u=%b want 1/500/1", bus.redirect, bus.target, bus.s_u); end
        n_cmp++;
        tick();
        tick();
        if ({bus.flush, bus.cause, bus.epc, bus.s_u} !== {1'b1, 4'hF, 32'h50C, 1'b0})
            begin n_bad++; $display("FAIL int_entry got f=%b cause=%h epc=%h s_u=%b want 1/f/50c/0", bus.flush, bus.cause, bus.epc, bus.s_u); end
        n_cmp++;
        drive(5'h00, 1'b0, 1'b0, 32'h510);
        tick();
        if ({bus.redirect, bus.target} !== {1'b1, 32'hF8})
            begin n_bad++; $display("FAIL int_redirect got r=%b tgt=%h want 1/f8", bus.redirect, bus.target); end
        n_cmp++;
        tick();
    endtask

    task automatic test_ignore_in_flush();
        drive(5'h12, 1'b0, 1'b0, 32'h600);
        tick();
        drive(5'h11, 1'b1, 1'b1, 32'h700);
        tick();
        if ({bus.redirect, bus.target, bus.epc, bus.cause} !== {1'b1, 32'h90, 32'h600, 4'h2})
            begin n_bad++; $display("FAIL flush_ignore got r=%b tgt=%h epc=%h cause=%h want 1/90/600/2", bus.redirect, bus.target, bus.epc, bus.cause); end
        n_cmp++;
        tick();
        drive(5'h00, 1'b0, 1'b0, 32'h0);
        if ({bus.busy, bus.target, bus.epc, bus.cause} !== {1'b0, 32'h90, 32'h600, 4'h2})
            begin n_bad++; $display("FAIL flush_exit got b=%b tgt=%h epc=%h cause=%h want 0/90/600/2", bus.busy, bus.target, bus.epc, bus.cause); end
        n_cmp++;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        drive(5'h15, 1'b0, 1'b0, 32'h800);
        tick();
        drive(5'h00, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        if ({bus.s_u, bus.flush, bus.redirect, bus.busy, bus.epc, bus.cause, bus.target} !== 72'h0)
            begin n_bad++; $display("FAIL rst_mid got s_u=%b f=%b r=%b b=%b epc=%h cause=%h tgt=%h want all 0", bus.s_u, bus.flush, bus.redirect, bus.busy, bus.epc, bus.cause, bus.target); end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        if ({bus.flush, bus.redirect} !== 2'b00)
            begin n_bad++; $display("FAIL rst_no_redirect got f/r=%b want 00", {bus.flush, bus.redirect}); end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [71:0] got, exp;
        logic [4:0]  v;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_left == 0 && $urandom_range(0, 5) == 0) set_user();
            v = ($urandom_range(0, 3) == 0) ? {1'b1, 4'($urandom_range(0, 15))} : 5'($urandom_range(0, 15));
            drive(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom);
            tick();
            got = {bus.s_u, bus.flush, bus.redirect, bus.busy, bus.epc, bus.cause, bus.target};
            exp = {m_su, 1'(m_left > 0), 1'(m_left == 1), 1'(m_left > 0), m_epc, m_cause, m_target};
            if (got !== exp)
                begin n_bad++; $display("FAIL rand_cycle%0d got %h want %h", i, got, exp); end
            n_cmp++;
        end
        drive(5'h00, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_exception();
        test_rfe();
        test_ext_int();
        test_ignore_in_flush();
        test_reset_mid_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
